// File: rtl/clb_cfg_loader.sv
// -----------------------------------------------------------------------------
// clb_cfg_loader
//   Serial configuration loader (write side of the CLB config interface).
//   Hunts for the 8-bit preamble 8'b1111_0010 in the serial stream. It then
//   receives NUM_CLB frames. Each frame is a start '0', CFG_W data bits sent
//   MSB first, an optional parity bit, and a stop '1'. Each good frame is
//   delivered as one parallel word written to CLB config register CFG_ADDR.
//
//   Optional feature macro: CLB_CFG_PARITY_EN
//     defined   : each frame carries one even-parity bit after the data bits.
//                 A parity mismatch sends the loader to the error state.
//     undefined : there is no parity bit, and DATA goes straight to STOP.
//
// Ports
//   K         in   clock, rising edge
//   RST_N     in   asynchronous active-low reset
//   PROG_N    in   synchronous restart (0 = abort to HUNT, clear DONE/ERR)
//   DIN       in   serial config bit
//   DIN_VLD   in   DIN qualifier; 0 stalls all state and counters
//   CFG_DATA  out  config word for CLB CFG_ADDR, held until the next write
//   CFG_ADDR  out  target CLB index
//   CFG_WE    out  one-cycle write strobe
//   BUSY      out  frame reception in progress (DATA/PAR/STOP)
//   DONE      out  all NUM_CLB frames loaded (sticky until PROG_N/RST_N)
//   ERR       out  framing or parity error (sticky until PROG_N/RST_N)
// -----------------------------------------------------------------------------
module clb_cfg_loader #(
   parameter int CFG_W   = 37,
   parameter int NUM_CLB = 4,
   parameter int AW      = 2
) (
   input  logic             K,
   input  logic             RST_N,
   input  logic             PROG_N,
   input  logic             DIN,
   input  logic             DIN_VLD,
   output logic [CFG_W-1:0] CFG_DATA,
   output logic [AW-1:0]    CFG_ADDR,
   output logic             CFG_WE,
   output logic             BUSY,
   output logic             DONE,
   output logic             ERR
);

   localparam logic [7:0]     PREAMBLE = 8'b1111_0010;
   localparam int             BCW      = $clog2(CFG_W);
   localparam logic [BCW-1:0] LAST_BIT = BCW'(CFG_W - 1);
   localparam logic [AW-1:0]  LAST_CLB = AW'(NUM_CLB - 1);

`ifdef CLB_CFG_PARITY_EN
   typedef enum logic [2:0] {HUNT, START, DATA, PAR, STOP, DONE_S, ERR_S} state_t;
`else
   typedef enum logic [2:0] {HUNT, START, DATA, STOP, DONE_S, ERR_S} state_t;
`endif

   state_t             state, state_nxt;
   logic [7:0]         win;
   logic [7:0]         win_nxt;
   logic [CFG_W-1:0]   shift_reg;
   logic [BCW-1:0]     bit_ctr;
   logic [AW-1:0]      frame_ctr;
   logic               wr_frame;
`ifdef CLB_CFG_PARITY_EN
   logic               par_acc;
`endif

   // State register
   always_ff @(posedge K or negedge RST_N) begin
      if (!RST_N) state <= HUNT;
      else        state <= state_nxt;
   end

   // Next-state logic. wr_frame marks the clock that accepts a good stop bit.
   always_comb begin
      state_nxt = state;
      win_nxt   = {win[6:0], DIN};
      wr_frame  = 1'b0;
      if (DIN_VLD) begin
         case (state)
            HUNT:  if (win_nxt == PREAMBLE) state_nxt = START;
            START: if (!DIN) state_nxt = DATA;
            DATA: begin
               if (bit_ctr == LAST_BIT) begin
`ifdef CLB_CFG_PARITY_EN
                  state_nxt = PAR;
`else
                  state_nxt = STOP;
`endif
               end
            end
`ifdef CLB_CFG_PARITY_EN
            // Even parity: the XOR of the data bits and the parity bit must be 0.
            PAR:   state_nxt = (par_acc ^ DIN) ? ERR_S : STOP;
`endif
            STOP: begin
               if (DIN) begin
                  wr_frame  = 1'b1;
                  state_nxt = (frame_ctr == LAST_CLB) ? DONE_S : START;
               end else begin
                  state_nxt = ERR_S;
               end
            end
            default: ;
         endcase
      end
      // PROG_N overrides any bit accepted on the same clock.
      if (!PROG_N) begin
         state_nxt = HUNT;
         wr_frame  = 1'b0;
      end
   end

   // Datapath: preamble window, shift register, counters, output registers.
   always_ff @(posedge K or negedge RST_N) begin
      if (!RST_N) begin
         win       <= '0;
         shift_reg <= '0;
         bit_ctr   <= '0;
         frame_ctr <= '0;
         CFG_DATA  <= '0;
         CFG_ADDR  <= '0;
         CFG_WE    <= 1'b0;
`ifdef CLB_CFG_PARITY_EN
         par_acc   <= 1'b0;
`endif
      end else begin
         CFG_WE <= wr_frame;
         if (wr_frame) begin
            CFG_DATA <= shift_reg;
            CFG_ADDR <= frame_ctr;
            // The counter stops at the last frame; DONE_S absorbs anything after it.
            if (frame_ctr != LAST_CLB) frame_ctr <= frame_ctr + AW'(1);
         end
         if (!PROG_N) begin
            win       <= '0;
            bit_ctr   <= '0;
            frame_ctr <= '0;
         end else if (DIN_VLD) begin
            case (state)
               // Clear the window on a match so a later return to HUNT starts fresh.
               HUNT:  win <= (win_nxt == PREAMBLE) ? 8'h00 : win_nxt;
               START: begin
                  bit_ctr <= '0;
`ifdef CLB_CFG_PARITY_EN
                  par_acc <= 1'b0;
`endif
               end
               DATA: begin
                  shift_reg <= {shift_reg[CFG_W-2:0], DIN};
                  bit_ctr   <= bit_ctr + BCW'(1);
`ifdef CLB_CFG_PARITY_EN
                  par_acc   <= par_acc ^ DIN;
`endif
               end
               default: ;
            endcase
         end
      end
   end

`ifdef CLB_CFG_PARITY_EN
   assign BUSY = (state == DATA) || (state == PAR) || (state == STOP);
`else
   assign BUSY = (state == DATA) || (state == STOP);
`endif
   assign DONE = (state == DONE_S);
   assign ERR  = (state == ERR_S);

endmodule

// File: tb/tb_clb_cfg_loader.sv
// -----------------------------------------------------------------------------
// tb_clb_cfg_loader
//   Directed self-checking bench for clb_cfg_loader (CFG_W=37, NUM_CLB=2).
//   The bench sends a parity bit per frame when CLB_CFG_PARITY_EN is defined.
// -----------------------------------------------------------------------------
module tb_clb_cfg_loader;

   localparam int CFG_W   = 37;
   localparam int NUM_CLB = 2;
   localparam int AW      = 1;

   logic             K       = 1'b0;
   logic             RST_N   = 1'b0;
   logic             PROG_N  = 1'b1;
   logic             DIN     = 1'b0;
   logic             DIN_VLD = 1'b0;
   logic [CFG_W-1:0] CFG_DATA;
   logic [AW-1:0]    CFG_ADDR;
   logic             CFG_WE, BUSY, DONE, ERR;

   int  n_chk  = 0;
   int  n_fail = 0;
   bit  stall  = 1'b0;
   int  base;

   int               wr_cnt  = 0;
   int               we_dbl  = 0;
   logic             we_prev = 1'b0;
   logic [AW-1:0]    wr_addr [32];
   logic [CFG_W-1:0] wr_data [32];

   clb_cfg_loader #(.CFG_W(CFG_W), .NUM_CLB(NUM_CLB), .AW(AW)) dut (
      .K(K), .RST_N(RST_N), .PROG_N(PROG_N), .DIN(DIN), .DIN_VLD(DIN_VLD),
      .CFG_DATA(CFG_DATA), .CFG_ADDR(CFG_ADDR), .CFG_WE(CFG_WE),
      .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
   );

   always #5 K = ~K;

   // Write log, sampled on the falling edge.
   always @(negedge K) begin
      if (CFG_WE === 1'b1) begin
         if (wr_cnt < 32) begin
            wr_addr[wr_cnt] <= CFG_ADDR;
            wr_data[wr_cnt] <= CFG_DATA;
         end
         wr_cnt <= wr_cnt + 1;
         if (we_prev) we_dbl <= we_dbl + 1;
      end
      we_prev <= CFG_WE;
   end

   // ---------------- stimulus helpers ----------------
   task automatic send_bit(input logic b);
      if (stall) begin
         @(negedge K); DIN = ~b; DIN_VLD = 1'b0;
      end
      @(negedge K); DIN = b; DIN_VLD = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(negedge K); DIN_VLD = 1'b0; end
   endtask

   task automatic send_byte(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) send_bit(v[i]);
   endtask

   task automatic send_data(input logic [CFG_W-1:0] d, input int nbits);
      for (int i = 0; i < nbits; i++) send_bit(d[CFG_W-1-i]);
   endtask

   task automatic send_frame(input logic [CFG_W-1:0] d, input logic stop);
      send_bit(1'b0);
      send_data(d, CFG_W);
`ifdef CLB_CFG_PARITY_EN
      send_bit(^d);
`endif
      send_bit(stop);
   endtask

`ifdef CLB_CFG_PARITY_EN
   task automatic send_frame_badpar(input logic [CFG_W-1:0] d);
      send_bit(1'b0);
      send_data(d, CFG_W);
      send_bit(~(^d));
      send_bit(1'b1);
   endtask
`endif

   task automatic prog_pulse;
      // DIN_VLD=1 alongside PROG_N=0 exercises the restart priority.
      @(negedge K); PROG_N = 1'b0; DIN = 1'b1; DIN_VLD = 1'b1;
      @(negedge K); PROG_N = 1'b1; DIN_VLD = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      RST_N = 1'b0;
      #12;
      n_chk++; if ({CFG_WE, BUSY, DONE, ERR} !== 4'b0000) begin n_fail++; $display("FAIL rst_flags: got %b expected 0000", {CFG_WE, BUSY, DONE, ERR}); end
      n_chk++; if (CFG_DATA !== '0) begin n_fail++; $display("FAIL rst_data: got %h expected 0", CFG_DATA); end
      n_chk++; if (CFG_ADDR !== '0) begin n_fail++; $display("FAIL rst_addr: got %h expected 0", CFG_ADDR); end
      @(negedge K); RST_N = 1'b1;
      idle(2);
   endtask

   task automatic test_basic;
      base = wr_cnt;
      send_bit(1); send_bit(0); send_bit(1);   // junk before the preamble
      send_byte(8'hF2);
      send_frame(37'h00_0000_0116, 1'b1);
      @(negedge K); DIN_VLD = 1'b0;
      n_chk++; if (CFG_WE !== 1'b1) begin n_fail++; $display("FAIL t1_we_lat0: got %b expected 1", CFG_WE); end
      n_chk++; if (CFG_DATA !== 37'h00_0000_0116) begin n_fail++; $display("FAIL t1_data_lat0: got %h expected 0000000116", CFG_DATA); end
      @(negedge K);
      n_chk++; if (CFG_WE !== 1'b0) begin n_fail++; $display("FAIL t1_we_pulse: got %b expected 0", CFG_WE); end
      n_chk++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL t1_busy_start: got %b expected 0", BUSY); end
      send_bit(1); send_bit(1);                 // idle ones between frames
      send_frame(37'h1F_FFFF_FFFF, 1'b1);
      @(negedge K); DIN_VLD = 1'b0;
      n_chk++; if ({CFG_WE, DONE} !== 2'b11) begin n_fail++; $display("FAIL t1_we_done: got %b expected 11", {CFG_WE, DONE}); end
      idle(3);
      n_chk++; if (wr_cnt - base !== 2) begin n_fail++; $display("FAIL t1_nwr: got %0d expected 2", wr_cnt - base); end
      n_chk++; if ({wr_addr[base], wr_addr[base+1]} !== 2'b01) begin n_fail++; $display("FAIL t1_addr: got %b expected 01", {wr_addr[base], wr_addr[base+1]}); end
      n_chk++; if (wr_data[base] !== 37'h00_0000_0116) begin n_fail++; $display("FAIL t1_data0: got %h expected 0000000116", wr_data[base]); end
      n_chk++; if (wr_data[base+1] !== 37'h1F_FFFF_FFFF) begin n_fail++; $display("FAIL t1_data1: got %h expected 1fffffffff", wr_data[base+1]); end
      n_chk++; if ({BUSY, DONE, ERR} !== 3'b010) begin n_fail++; $display("FAIL t1_flags: got %b expected 010", {BUSY, DONE, ERR}); end
   endtask

   task automatic test_stall;
      prog_pulse;
      n_chk++; if ({DONE, ERR} !== 2'b00) begin n_fail++; $display("FAIL t2_prog_clr: got %b expected 00", {DONE, ERR}); end
      base  = wr_cnt;
      stall = 1'b1;
      send_byte(8'hF2);
      send_frame(37'h00_0000_0116, 1'b1);
      send_frame(37'h1F_FFFF_FFFF, 1'b1);
      send_frame(37'h00_0000_0005, 1'b1);       // extra frame after DONE must be ignored
      stall = 1'b0;
      idle(3);
      n_chk++; if (wr_cnt - base !== 2) begin n_fail++; $display("FAIL t2_nwr: got %0d expected 2", wr_cnt - base); end
      n_chk++; if (wr_data[base] !== 37'h00_0000_0116 || wr_addr[base] !== 1'b0) begin n_fail++; $display("FAIL t2_wr0: got %h@%b expected 0000000116@0", wr_data[base], wr_addr[base]); end
      n_chk++; if (wr_data[base+1] !== 37'h1F_FFFF_FFFF || wr_addr[base+1] !== 1'b1) begin n_fail++; $display("FAIL t2_wr1: got %h@%b expected 1fffffffff@1", wr_data[base+1], wr_addr[base+1]); end
      n_chk++; if ({DONE, ERR} !== 2'b10) begin n_fail++; $display("FAIL t2_done: got %b expected 10", {DONE, ERR}); end
   endtask

   task automatic test_stop_err;
      prog_pulse;
      base = wr_cnt;
      send_byte(8'hF2);
      send_frame(37'h00_0000_0116, 1'b0);
      @(negedge K); DIN_VLD = 1'b0;
      n_chk++; if ({CFG_WE, ERR} !== 2'b01) begin n_fail++; $display("FAIL t3_err: got %b expected 01", {CFG_WE, ERR}); end
      idle(3);
      n_chk++; if (wr_cnt - base !== 0) begin n_fail++; $display("FAIL t3_nwr: got %0d expected 0", wr_cnt - base); end
      n_chk++; if ({BUSY, DONE} !== 2'b00) begin n_fail++; $display("FAIL t3_busy_done: got %b expected 00", {BUSY, DONE}); end
      prog_pulse;
      n_chk++; if (ERR !== 1'b0) begin n_fail++; $display("FAIL t3_err_clr: got %b expected 0", ERR); end
      send_byte(8'hF2); send_bit(0);
      idle(1);
      n_chk++; if (BUSY !== 1'b1) begin n_fail++; $display("FAIL t3_rehunt: got %b expected 1", BUSY); end
   endtask

   task automatic test_parity;
      prog_pulse;
      base = wr_cnt;
      send_byte(8'hF2);
      send_frame(37'h0A_5A5A_5A5A, 1'b1);
      send_bit(1);
`ifdef CLB_CFG_PARITY_EN
      send_frame_badpar(37'h15_A5A5_A5A5);
      idle(3);
      n_chk++; if (wr_cnt - base !== 1) begin n_fail++; $display("FAIL t4_nwr: got %0d expected 1", wr_cnt - base); end
      n_chk++; if (wr_data[base] !== 37'h0A_5A5A_5A5A || wr_addr[base] !== 1'b0) begin n_fail++; $display("FAIL t4_wr0: got %h@%b expected 0a5a5a5a5a@0", wr_data[base], wr_addr[base]); end
      n_chk++; if ({DONE, ERR} !== 2'b01) begin n_fail++; $display("FAIL t4_err: got %b expected 01", {DONE, ERR}); end
      n_chk++; if (CFG_DATA !== 37'h0A_5A5A_5A5A) begin n_fail++; $display("FAIL t4_hold: got %h expected 0a5a5a5a5a", CFG_DATA); end
`else
      send_frame(37'h15_A5A5_A5A5, 1'b1);
      idle(3);
      n_chk++; if (wr_cnt - base !== 2) begin n_fail++; $display("FAIL t4_nwr: got %0d expected 2", wr_cnt - base); end
      n_chk++; if (wr_data[base] !== 37'h0A_5A5A_5A5A || wr_addr[base] !== 1'b0) begin n_fail++; $display("FAIL t4_wr0: got %h@%b expected 0a5a5a5a5a@0", wr_data[base], wr_addr[base]); end
      n_chk++; if (wr_data[base+1] !== 37'h15_A5A5_A5A5 || wr_addr[base+1] !== 1'b1) begin n_fail++; $display("FAIL t4_wr1: got %h@%b expected 15a5a5a5a5@1", wr_data[base+1], wr_addr[base+1]); end
      n_chk++; if ({DONE, ERR} !== 2'b10) begin n_fail++; $display("FAIL t4_done: got %b expected 10", {DONE, ERR}); end
`endif
   endtask

   task automatic test_abort;
      prog_pulse;
      base = wr_cnt;
      send_byte(8'hF2);
      send_bit(0);
      send_data(37'h1E_EEEE_EEEE, 20);
      idle(1);
      n_chk++; if (BUSY !== 1'b1) begin n_fail++; $display("FAIL t5_busy: got %b expected 1", BUSY); end
      prog_pulse;
      n_chk++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL t5_abort: got %b expected 0", BUSY); end
      send_byte(8'hF2);
      send_frame(37'h12_3456_789A, 1'b1);
      send_frame(37'h00_0000_0001, 1'b1);
      idle(3);
      n_chk++; if (wr_cnt - base !== 2) begin n_fail++; $display("FAIL t5_nwr: got %0d expected 2", wr_cnt - base); end
      n_chk++; if (wr_data[base] !== 37'h12_3456_789A || wr_addr[base] !== 1'b0) begin n_fail++; $display("FAIL t5_wr0: got %h@%b expected 123456789a@0", wr_data[base], wr_addr[base]); end
      n_chk++; if (wr_data[base+1] !== 37'h00_0000_0001 || wr_addr[base+1] !== 1'b1) begin n_fail++; $display("FAIL t5_wr1: got %h@%b expected 0000000001@1", wr_data[base+1], wr_addr[base+1]); end
      n_chk++; if (DONE !== 1'b1) begin n_fail++; $display("FAIL t5_done: got %b expected 1", DONE); end
   endtask

   task automatic test_async_reset;
      prog_pulse;
      send_byte(8'hF2);
      send_bit(0);
      send_data(37'h1F_0000_FFFF, 10);
      @(posedge K); #2;
      n_chk++; if ({BUSY, CFG_DATA} !== {1'b1, 37'h00_0000_0001}) begin n_fail++; $display("FAIL t6_pre: got %b/%h expected 1/0000000001", BUSY, CFG_DATA); end
      RST_N = 1'b0;
      #1;
      n_chk++; if ({CFG_WE, BUSY, DONE, ERR} !== 4'b0000) begin n_fail++; $display("FAIL t6_flags: got %b expected 0000", {CFG_WE, BUSY, DONE, ERR}); end
      n_chk++; if ({CFG_ADDR, CFG_DATA} !== '0) begin n_fail++; $display("FAIL t6_outs: got %b/%h expected 0/0", CFG_ADDR, CFG_DATA); end
      @(negedge K); RST_N = 1'b1; DIN_VLD = 1'b0;
      base = wr_cnt;
      send_byte(8'hF2);
      send_frame(37'h00_0000_0116, 1'b1);
      send_frame(37'h1E_DCBA_9876, 1'b1);
      idle(3);
      n_chk++; if (wr_cnt - base !== 2) begin n_fail++; $display("FAIL t6_nwr: got %0d expected 2", wr_cnt - base); end
      n_chk++; if (wr_data[base+1] !== 37'h1E_DCBA_9876 || wr_addr[base+1] !== 1'b1) begin n_fail++; $display("FAIL t6_wr1: got %h@%b expected 1edcba9876@1", wr_data[base+1], wr_addr[base+1]); end
      n_chk++; if (DONE !== 1'b1) begin n_fail++; $display("FAIL t6_done: got %b expected 1", DONE); end
   endtask

   task automatic test_strobe_spacing;
      n_chk++; if (we_dbl !== 0) begin n_fail++; $display("FAIL we_back2back: got %0d expected 0", we_dbl); end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_stall;
      test_stop_err;
      test_parity;
      test_abort;
      test_async_reset;
      test_strobe_spacing;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
